// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode-stage instruction in, stall/forward/destination
// and HI/LO-busy status out. The pipeline datapath is the master side and the
// hazard controller is the slave side.
interface hazard_ctrl_if;
  logic [31:0] instr_d;
  logic        stall;
  logic [1:0]  fwd_rs_d;
  logic [1:0]  fwd_rt_d;
  logic [1:0]  fwd_rs_e;
  logic [1:0]  fwd_rt_e;
  logic [4:0]  a3_e;
  logic [4:0]  a3_m;
  logic [4:0]  a3_w;
  logic        md_busy;

  modport master (
    output instr_d,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
    input  a3_e, a3_m, a3_w, md_busy
  );

  modport slave (
    input  instr_d,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
    output a3_e, a3_m, a3_w, md_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage MIPS-subset hazard controller. Decodes the D-stage instruction into
// destination / Tuse / Tnew, tracks destination and Tnew through E, M and W,
// raises stall for data and HI/LO hazards and selects forwarding paths for the
// D-stage compare/jr operands and the E-stage ALU/MD operands.
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hif
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_op_t;

  // Instruction fields
  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [4:0] rs_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;

  // Decode results
  logic       use_rs_s;
  logic       use_rt_s;
  logic [1:0] tuse_rs_s;
  logic [1:0] tuse_rt_s;
  logic [4:0] a3_d_s;
  logic [1:0] tnew_d_s;
  md_op_t     md_d_s;
  logic       is_md_s;
  logic [4:0] rs_d_s;
  logic [4:0] rt_d_s;

  // Pipeline tracking state
  logic [4:0] a3_e_r;
  logic [1:0] tnew_e_r;
  md_op_t     md_e_r;
  logic [4:0] rs_e_r;
  logic [4:0] rt_e_r;
  logic [4:0] a3_m_r;
  logic [1:0] tnew_m_r;
  logic [4:0] a3_w_r;

  // HI/LO busy counter
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             busy_r;

  logic data_stall_s;
  logic md_stall_s;
  logic stall_s;

  assign op_s    = hif.instr_d[31:26];
  assign rs_s    = hif.instr_d[25:21];
  assign rt_s    = hif.instr_d[20:16];
  assign rd_s    = hif.instr_d[15:11];
  assign funct_s = hif.instr_d[5:0];

  // A producer blocks the reader when its result is still further away than the reader's need.
  function automatic logic hazard_on(input logic [4:0] r, input logic [1:0] tuse,
                                     input logic [4:0] ae, input logic [1:0] te,
                                     input logic [4:0] am, input logic [1:0] tm);
    return (r != 5'd0) && (((ae == r) && (te > tuse)) || ((am == r) && (tm > tuse)));
  endfunction

  // D-stage operand source: the youngest stage whose result is already available wins.
  function automatic logic [1:0] fwd_d_sel(input logic [4:0] r,
                                           input logic [4:0] ae, input logic [1:0] te,
                                           input logic [4:0] am, input logic [1:0] tm);
    logic [1:0] sel;
    if ((r != 5'd0) && (ae == r) && (te == 2'd0)) begin
      sel = 2'd1;
    end else if ((r != 5'd0) && (am == r) && (tm == 2'd0)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // E-stage operand source: M when its result is ready, else W, else the pipeline register.
  function automatic logic [1:0] fwd_e_sel(input logic [4:0] r,
                                           input logic [4:0] am, input logic [1:0] tm,
                                           input logic [4:0] aw);
    logic [1:0] sel;
    if ((r != 5'd0) && (am == r) && (tm == 2'd0)) begin
      sel = 2'd1;
    end else if ((r != 5'd0) && (aw == r)) begin
      sel = 2'd2;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  // Decode the D-stage instruction into read-set, Tuse, destination, Tnew and HI/LO class.
  always_comb begin
    use_rs_s  = 1'b0;
    use_rt_s  = 1'b0;
    tuse_rs_s = 2'd0;
    tuse_rt_s = 2'd0;
    a3_d_s    = 5'd0;
    tnew_d_s  = 2'd0;
    md_d_s    = MD_NONE;
    is_md_s   = 1'b0;
    case (op_s)
      OP_SPECIAL: begin
        case (funct_s)
          FN_ADDU, FN_SUBU, FN_AND, FN_SLT: begin
            use_rs_s  = 1'b1;
            tuse_rs_s = 2'd1;
            use_rt_s  = 1'b1;
            tuse_rt_s = 2'd1;
            a3_d_s    = rd_s;
            tnew_d_s  = 2'd1;
          end
          FN_SLL: begin
            use_rt_s  = 1'b1;
            tuse_rt_s = 2'd1;
            a3_d_s    = rd_s;
            tnew_d_s  = 2'd1;
          end
          FN_JR: begin
            use_rs_s  = 1'b1;
            tuse_rs_s = 2'd0;
          end
          FN_JALR: begin
            use_rs_s  = 1'b1;
            tuse_rs_s = 2'd0;
            a3_d_s    = rd_s;
            tnew_d_s  = 2'd0;
          end
          FN_MULT, FN_MULTU: begin
            use_rs_s  = 1'b1;
            tuse_rs_s = 2'd1;
            use_rt_s  = 1'b1;
            tuse_rt_s = 2'd1;
            md_d_s    = MD_MULT;
            is_md_s   = 1'b1;
          end
          FN_DIV, FN_DIVU: begin
            use_rs_s  = 1'b1;
            tuse_rs_s = 2'd1;
            use_rt_s  = 1'b1;
            tuse_rt_s = 2'd1;
            md_d_s    = MD_DIV;
            is_md_s   = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            a3_d_s   = rd_s;
            tnew_d_s = 2'd1;
            is_md_s  = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            use_rs_s  = 1'b1;
            tuse_rs_s = 2'd1;
            is_md_s   = 1'b1;
          end
          default: begin
            a3_d_s = 5'd0;
          end
        endcase
      end
      OP_ORI, OP_ADDIU: begin
        use_rs_s  = 1'b1;
        tuse_rs_s = 2'd1;
        a3_d_s    = rt_s;
        tnew_d_s  = 2'd1;
      end
      OP_LUI: begin
        a3_d_s   = rt_s;
        tnew_d_s = 2'd1;
      end
      OP_LW, OP_LH, OP_LB: begin
        use_rs_s  = 1'b1;
        tuse_rs_s = 2'd1;
        a3_d_s    = rt_s;
        tnew_d_s  = 2'd2;
      end
      OP_SW, OP_SH, OP_SB: begin
        use_rs_s  = 1'b1;
        tuse_rs_s = 2'd1;
        use_rt_s  = 1'b1;
        tuse_rt_s = 2'd2;
      end
      OP_BEQ: begin
        use_rs_s  = 1'b1;
        tuse_rs_s = 2'd0;
        use_rt_s  = 1'b1;
        tuse_rt_s = 2'd0;
      end
      OP_JAL: begin
        a3_d_s   = 5'd31;
        tnew_d_s = 2'd0;
      end
      OP_J: begin
        a3_d_s = 5'd0;
      end
      default: begin
        a3_d_s = 5'd0;
      end
    endcase
  end

  // Fields the instruction does not read are zeroed so they can neither stall nor forward.
  assign rs_d_s = use_rs_s ? rs_s : 5'd0;
  assign rt_d_s = use_rt_s ? rt_s : 5'd0;

  // Stall is a pure function of D decode and current stage state, valid in the same cycle.
  always_comb begin
    data_stall_s = hazard_on(rs_d_s, tuse_rs_s, a3_e_r, tnew_e_r, a3_m_r, tnew_m_r) |
                   hazard_on(rt_d_s, tuse_rt_s, a3_e_r, tnew_e_r, a3_m_r, tnew_m_r);
    md_stall_s   = is_md_s && (busy_r || (md_e_r != MD_NONE));
    stall_s      = data_stall_s | md_stall_s;
  end

  // Advance destination/Tnew/HI-LO tags through E, M and W; a stall drops a bubble into E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_e_r   <= 5'd0;
      tnew_e_r <= 2'd0;
      md_e_r   <= MD_NONE;
      rs_e_r   <= 5'd0;
      rt_e_r   <= 5'd0;
      a3_m_r   <= 5'd0;
      tnew_m_r <= 2'd0;
      a3_w_r   <= 5'd0;
    end else begin
      if (stall_s) begin
        a3_e_r   <= 5'd0;
        tnew_e_r <= 2'd0;
        md_e_r   <= MD_NONE;
        rs_e_r   <= 5'd0;
        rt_e_r   <= 5'd0;
      end else begin
        a3_e_r   <= a3_d_s;
        tnew_e_r <= tnew_d_s;
        md_e_r   <= md_d_s;
        rs_e_r   <= rs_d_s;
        rt_e_r   <= rt_d_s;
      end
      a3_m_r   <= a3_e_r;
      tnew_m_r <= (tnew_e_r != 2'd0) ? (tnew_e_r - 2'd1) : 2'd0;
      a3_w_r   <= a3_m_r;
    end
  end

  // Busy counter: a mult/div in E reloads the latency, otherwise count down to zero.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case (md_e_r)
      MD_MULT: cnt_nxt_s = CNT_W'(MULT_CYC);
      MD_DIV:  cnt_nxt_s = CNT_W'(DIV_CYC);
      default: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_nxt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
    endcase
  end

  // Register the counter and its nonzero flag together so md_busy comes straight from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      busy_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      busy_r <= (cnt_nxt_s != {CNT_W{1'b0}});
    end
  end

  assign hif.stall    = stall_s;
  assign hif.fwd_rs_d = fwd_d_sel(rs_d_s, a3_e_r, tnew_e_r, a3_m_r, tnew_m_r);
  assign hif.fwd_rt_d = fwd_d_sel(rt_d_s, a3_e_r, tnew_e_r, a3_m_r, tnew_m_r);
  assign hif.fwd_rs_e = fwd_e_sel(rs_e_r, a3_m_r, tnew_m_r, a3_w_r);
  assign hif.fwd_rt_e = fwd_e_sel(rt_e_r, a3_m_r, tnew_m_r, a3_w_r);
  assign hif.a3_e     = a3_e_r;
  assign hif.a3_m     = a3_m_r;
  assign hif.a3_w     = a3_w_r;
  assign hif.md_busy  = busy_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Each cycle the stimulus drives instr_d and
// queues the hand-computed expected output vector; a negedge monitor pops and
// compares it against the DUT outputs.
module tb_hazard_ctrl;
  logic clk;
  logic reset;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif)
  );

  // Vector layout: stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, a3_e, a3_m, a3_w, md_busy
  logic [24:0] exp_q[$];
  string       nm_q[$];
  int          n_chk;
  int          n_fail;

  logic [31:0] NOP, LW1, ADDU213, ADDU1, BEQ10, MULT, DIV, MFLO, ADDU0, ADDU200, JAL, JR31;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0000};
  endfunction

  function automatic logic [24:0] mk(input logic s, input logic [1:0] frd, input logic [1:0] frt,
                                     input logic [1:0] fre, input logic [1:0] fte,
                                     input logic [4:0] ae, input logic [4:0] am,
                                     input logic [4:0] aw, input logic b);
    return {s, frd, frt, fre, fte, ae, am, aw, b};
  endfunction

  task automatic cyc(input logic [31:0] ins, input logic [24:0] e, input string nm);
    @(posedge clk);
    #1;
    hif.instr_d = ins;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // mult/div followed immediately by mflo $4; n = number of busy cycles expected.
  task automatic md_seq(input logic [31:0] op, input int n, input string nm);
    cyc(op,   mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0), {nm, "_issue"});
    cyc(MFLO, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0), {nm, "_stall_e"});
    for (int i = 0; i < n; i++)
      cyc(MFLO, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1), {nm, "_stall_busy"});
    cyc(MFLO, mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0), {nm, "_release"});
    cyc(NOP,  mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd4, 5'd0, 5'd0, 1'b0), {nm, "_mflo_e"});
    cyc(NOP,  mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd4, 5'd0, 1'b0), {nm, "_mflo_m"});
    cyc(NOP,  mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd4, 1'b0), {nm, "_mflo_w"});
    cyc(NOP,  mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0), {nm, "_drain"});
  endtask

  // Monitor: compare the queued expectation with the DUT outputs on every falling edge.
  always @(negedge clk) begin
    logic [24:0] e;
    logic [24:0] a;
    string       nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      a  = {hif.stall, hif.fwd_rs_d, hif.fwd_rt_d, hif.fwd_rs_e, hif.fwd_rt_e,
            hif.a3_e, hif.a3_m, hif.a3_w, hif.md_busy};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: actual stall=%b fd=%0d/%0d fe=%0d/%0d a3=%0d/%0d/%0d busy=%b, required stall=%b fd=%0d/%0d fe=%0d/%0d a3=%0d/%0d/%0d busy=%b",
                 nm, a[24], a[23:22], a[21:20], a[19:18], a[17:16], a[15:11], a[10:6], a[5:1], a[0],
                 e[24], e[23:22], e[21:20], e[19:18], e[17:16], e[15:11], e[10:6], e[5:1], e[0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [24:0] z;
    n_chk   = 0;
    n_fail  = 0;
    z       = mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    NOP     = 32'h0000_0000;
    LW1     = itype(6'b100011, 5'd5, 5'd1);
    ADDU213 = rtype(5'd1, 5'd3, 5'd2, 6'b100001);
    ADDU1   = rtype(5'd2, 5'd3, 5'd1, 6'b100001);
    BEQ10   = itype(6'b000100, 5'd1, 5'd0);
    MULT    = rtype(5'd2, 5'd3, 5'd0, 6'b011000);
    DIV     = rtype(5'd2, 5'd3, 5'd0, 6'b011010);
    MFLO    = rtype(5'd0, 5'd0, 5'd4, 6'b010010);
    ADDU0   = rtype(5'd2, 5'd3, 5'd0, 6'b100001);
    ADDU200 = rtype(5'd0, 5'd0, 5'd2, 6'b100001);
    JAL     = {6'b000011, 26'h0000010};
    JR31    = rtype(5'd31, 5'd0, 5'd0, 6'b001000);

    // Reset state, with a hazard-looking instruction present in D
    reset       = 1'b0;
    hif.instr_d = ADDU213;
    #1;
    exp_q.push_back(z);
    nm_q.push_back("reset_state");
    #10;
    hif.instr_d = NOP;
    #1;
    reset = 1'b1;

    // Load-use: one stall cycle, then W forwards to E
    cyc(LW1,     z, "lu_lw_d");
    cyc(ADDU213, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd1, 5'd0, 5'd0, 1'b0), "lu_stall");
    cyc(ADDU213, mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd1, 5'd0, 1'b0), "lu_release");
    cyc(NOP,     mk(1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 5'd2, 5'd0, 5'd1, 1'b0), "lu_fwd_rs_e_w");
    cyc(NOP,     mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd2, 5'd0, 1'b0), "lu_addu_m");
    cyc(NOP,     mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd2, 1'b0), "lu_addu_w");
    cyc(NOP,     z, "lu_drain");

    // Branch after ALU: one stall, then M forwards to the D compare
    cyc(ADDU1, z, "br_addu_d");
    cyc(BEQ10, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd1, 5'd0, 5'd0, 1'b0), "br_stall");
    cyc(BEQ10, mk(1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 5'd0, 5'd1, 5'd0, 1'b0), "br_fwd_rs_d_m");
    cyc(NOP,   mk(1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 5'd0, 5'd0, 5'd1, 1'b0), "br_beq_e");
    cyc(NOP,   z, "br_drain");

    // HI/LO: mult blocks mflo for 6 cycles, div for 11
    md_seq(MULT, 5, "mult");
    md_seq(DIV, 10, "div");

    // Register 0 never stalls or forwards
    cyc(ADDU0,   z, "r0_addu0_d");
    cyc(ADDU200, z, "r0_no_stall");
    cyc(NOP,     mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd2, 5'd0, 5'd0, 1'b0), "r0_no_fwd_e");
    cyc(NOP,     mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd2, 5'd0, 1'b0), "r0_m");
    cyc(NOP,     mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd2, 1'b0), "r0_w");
    cyc(NOP,     z, "r0_drain");

    // jal result is available immediately: jr $31 forwards from E without stalling
    cyc(JAL,  z, "jal_d");
    cyc(JR31, mk(1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 5'd31, 5'd0, 5'd0, 1'b0), "jr_fwd_rs_d_e");
    cyc(NOP,  mk(1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 5'd0, 5'd31, 5'd0, 1'b0), "jr_fwd_rs_e_m");
    cyc(NOP,  mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd31, 1'b0), "jal_w");
    cyc(NOP,  z, "jal_drain");

    // Simultaneous hazards: lw $1 in E and mflo in D while busy
    cyc(MULT, z, "sim_mult_d");
    cyc(LW1,  z, "sim_lw_d");
    cyc(MFLO, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd1, 5'd0, 5'd0, 1'b1), "sim_both");
    cyc(MFLO, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd1, 5'd0, 1'b1), "sim_busy1");
    cyc(MFLO, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd1, 1'b1), "sim_busy2");
    cyc(MFLO, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1), "sim_busy3");
    cyc(MFLO, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1), "sim_busy4");
    cyc(MFLO, z, "sim_release");
    cyc(NOP,  mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd4, 5'd0, 5'd0, 1'b0), "sim_mflo_e");
    cyc(NOP,  mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd4, 5'd0, 1'b0), "sim_mflo_m");
    cyc(NOP,  mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd4, 1'b0), "sim_mflo_w");
    cyc(NOP,  z, "sim_drain");

    // Reset mid-operation with cnt = 3 and stall active
    cyc(MULT, z, "rst_mult_d");
    cyc(MFLO, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b0), "rst_pre_e");
    cyc(MFLO, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1), "rst_pre_c5");
    cyc(MFLO, mk(1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1), "rst_pre_c4");
    @(posedge clk);
    #1;
    hif.instr_d = MFLO;
    #1;
    reset = 1'b0;
    exp_q.push_back(z);
    nm_q.push_back("rst_async_clear");
    cyc(MULT, z, "rst_hold1");
    cyc(MULT, z, "rst_hold2");
    @(negedge clk);
    #2;
    reset = 1'b1;
    cyc(NOP, z, "rel_mult_e");
    for (int i = 0; i < 5; i++)
      cyc(NOP, mk(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 5'd0, 5'd0, 5'd0, 1'b1), "rel_busy");
    cyc(NOP, z, "rel_idle");

    repeat (2) @(posedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: actual %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
